// File: rtl/cc_block_arb.sv
// Round-robin arbiter sharing one ChaCha20 block engine between two requesters.
// Operands are latched at grant; the result or a watchdog timeout is returned to the owner.
module cc_block_arb #(
    parameter int MAX_WAIT = 1024
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [1:0]   i_req,
    input  logic [255:0] i_key0,
    input  logic [95:0]  i_non0,
    input  logic [31:0]  i_cnt0,
    input  logic [255:0] i_key1,
    input  logic [95:0]  i_non1,
    input  logic [31:0]  i_cnt1,
    output logic [1:0]   o_gnt,
    output logic [1:0]   o_vld,
    output logic [1:0]   o_err,
    output logic [511:0] o_stream,
    output logic         o_busy,
    output logic         o_blk_start,
    output logic [255:0] o_blk_key,
    output logic [95:0]  o_blk_non,
    output logic [31:0]  o_blk_cnt,
    input  logic [511:0] i_blk_stream,
    input  logic         i_blk_done
);

    localparam int CW = $clog2(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t        state;
    logic          r_ptr;
    logic          r_sel;
    logic [CW-1:0] wait_cnt;
    logic          pick;

    // Contention resolves to the pointer; a lone request wins outright.
    always_comb begin
        pick = (i_req == 2'b11) ? r_ptr : i_req[1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            r_ptr       <= 1'b0;
            r_sel       <= 1'b0;
            wait_cnt    <= '0;
            o_gnt       <= '0;
            o_vld       <= '0;
            o_err       <= '0;
            o_stream    <= '0;
            o_busy      <= 1'b0;
            o_blk_start <= 1'b0;
            o_blk_key   <= '0;
            o_blk_non   <= '0;
            o_blk_cnt   <= '0;
        end else begin
            o_gnt       <= '0;
            o_vld       <= '0;
            o_err       <= '0;
            o_blk_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        o_gnt[pick] <= 1'b1;
                        o_blk_start <= 1'b1;
                        o_blk_key   <= pick ? i_key1 : i_key0;
                        o_blk_non   <= pick ? i_non1 : i_non0;
                        o_blk_cnt   <= pick ? i_cnt1 : i_cnt0;
                        r_sel       <= pick;
                        wait_cnt    <= '0;
                        state       <= RUN;
                        o_busy      <= 1'b1;
                    end
                end
                RUN: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // Completion takes precedence over a simultaneous timeout.
                    if (i_blk_done) begin
                        o_stream     <= i_blk_stream;
                        o_vld[r_sel] <= 1'b1;
                        state        <= RESP;
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        o_err[r_sel] <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    r_ptr  <= ~r_sel;
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_block_arb.sv
// Directed bench for cc_block_arb: a main instance (MAX_WAIT=1024) and a short-watchdog
// instance (MAX_WAIT=16) share stimulus and a behavioural engine model.
module tb_cc_block_arb;

    logic         clk, rst;
    logic [1:0]   req;
    logic [255:0] key0, key1;
    logic [95:0]  non0, non1;
    logic [31:0]  cnt0, cnt1;
    logic [511:0] blk_stream;
    logic         blk_done;

    logic [1:0]   gnt, vld, err;
    logic [511:0] stream;
    logic         busy, blk_start;
    logic [255:0] blk_key;
    logic [95:0]  blk_non;
    logic [31:0]  blk_cnt;

    logic [1:0]   s_gnt, s_vld, s_err;
    logic [511:0] s_stream;
    logic         s_busy, s_blk_start;
    logic [255:0] s_blk_key;
    logic [95:0]  s_blk_non;
    logic [31:0]  s_blk_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int           eng_mode;   // 0: fixed A5 block, 1: derived from operands, 2: never done
    int           eng_lat;
    int           eng_cnt;
    logic [511:0] eng_val;

    cc_block_arb #(.MAX_WAIT(1024)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_key0(key0), .i_non0(non0), .i_cnt0(cnt0),
        .i_key1(key1), .i_non1(non1), .i_cnt1(cnt1),
        .o_gnt(gnt), .o_vld(vld), .o_err(err), .o_stream(stream), .o_busy(busy),
        .o_blk_start(blk_start), .o_blk_key(blk_key), .o_blk_non(blk_non), .o_blk_cnt(blk_cnt),
        .i_blk_stream(blk_stream), .i_blk_done(blk_done)
    );

    cc_block_arb #(.MAX_WAIT(16)) u_dut_wd (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_key0(key0), .i_non0(non0), .i_cnt0(cnt0),
        .i_key1(key1), .i_non1(non1), .i_cnt1(cnt1),
        .o_gnt(s_gnt), .o_vld(s_vld), .o_err(s_err), .o_stream(s_stream), .o_busy(s_busy),
        .o_blk_start(s_blk_start), .o_blk_key(s_blk_key), .o_blk_non(s_blk_non), .o_blk_cnt(s_blk_cnt),
        .i_blk_stream(blk_stream), .i_blk_done(blk_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine model keyed on the main instance's start: done arrives eng_lat cycles after start.
    initial begin
        blk_done   = 1'b0;
        blk_stream = '0;
        eng_cnt    = 0;
        eng_val    = '0;
        forever begin
            @(negedge clk);
            blk_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    blk_done   = 1'b1;
                    blk_stream = eng_val;
                end
            end
            if (blk_start && eng_mode != 2) begin
                eng_cnt = eng_lat;
                eng_val = (eng_mode == 0) ? {64{8'hA5}} : ({blk_key, blk_key} ^ {16{blk_cnt}});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic logic [511:0] exp_stream(input logic [255:0] k, input logic [31:0] c);
        return {k, k} ^ {16{c}};
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind: 0 gnt, 1 vld, 2 err, 3 s_gnt, 4 s_vld, 5 s_err
    task automatic wait_sig(input string tag, input int kind, output logic [1:0] v, output int t);
        v = '0;
        t = 0;
        for (int i = 0; i < 200 && v == 2'b00; i++) begin
            @(negedge clk);
            case (kind)
                0:       v = gnt;
                1:       v = vld;
                2:       v = err;
                3:       v = s_gnt;
                4:       v = s_vld;
                default: v = s_err;
            endcase
            t = cyc;
        end
        check({tag, "_seen"}, 512'(v != 2'b00), 512'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        eng_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [1:0] v;
    int         t0, tg, tg_prev, tv, ts, te, hits;

    initial begin
        rst      = 1'b0;
        req      = '0;
        key0     = {8{32'hC0DE_0000}};
        key1     = {8{32'h0000_BEEF}};
        non0     = {3{32'hAAAA_0001}};
        non1     = {3{32'h5555_0002}};
        cnt0     = 32'd1;
        cnt1     = 32'd0;
        eng_mode = 0;
        eng_lat  = 20;

        // Reset then a single request with a 20-cycle engine
        do_reset();
        check("rst_outs", 512'({gnt, vld, err, busy, blk_start}), 512'd0);
        check("rst_stream", stream, '0);
        check("rst_blk", 512'({blk_key, blk_non, blk_cnt}), '0);
        req = 2'b01;
        t0  = cyc;
        wait_sig("t1_gnt", 0, v, tg);
        check("t1_gnt", 512'(v), 512'd1);
        check("t1_gnt_lat", 512'(tg - t0), 512'd1);
        check("t1_start", 512'(blk_start), 512'd1);
        check("t1_blk_cnt", 512'(blk_cnt), 512'd1);
        check("t1_blk_key", 512'(blk_key), 512'(key0));
        check("t1_blk_non", 512'(blk_non), 512'(non0));
        req = 2'b00;
        @(negedge clk);
        check("t1_pulse_end", 512'({gnt, blk_start}), 512'd0);
        check("t1_busy_run", 512'(busy), 512'd1);
        wait_sig("t1_vld", 1, v, tv);
        check("t1_vld", 512'(v), 512'd1);
        check("t1_vld_lat", 512'(tv - tg), 512'd21);
        check("t1_stream", stream, {64{8'hA5}});
        check("t1_no_err", 512'(err), 512'd0);
        @(negedge clk);
        check("t1_vld_end", 512'(vld), 512'd0);
        check("t1_busy_idle", 512'(busy), 512'd0);

        // Simultaneous requests from reset, then continuous contention
        do_reset();
        eng_mode = 1;
        eng_lat  = 5;
        req      = 2'b11;
        wait_sig("t2_gnt0", 0, v, tg);
        check("t2_gnt0", 512'(v), 512'd1);
        check("t2_cnt0", 512'(blk_cnt), 512'(cnt0));
        req = 2'b10;
        wait_sig("t2_vld0", 1, v, tv);
        check("t2_vld0", 512'(v), 512'd1);
        check("t2_stream0", stream, exp_stream(key0, cnt0));
        tg_prev = tg;
        wait_sig("t2_gnt1", 0, v, tg);
        check("t2_gnt1", 512'(v), 512'd2);
        check("t2_gnt1_after_resp", 512'(tg - tv), 512'd2);
        check("t2_spacing", 512'(tg - tg_prev), 512'd8);
        check("t2_cnt1", 512'(blk_cnt), 512'd0);
        check("t2_key1", 512'(blk_key), 512'(key1));
        req = 2'b00;
        wait_sig("t2_vld1", 1, v, tv);
        check("t2_vld1", 512'(v), 512'd2);
        check("t2_stream1", stream, exp_stream(key1, cnt1));
        req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            wait_sig("t3_gnt", 0, v, tg);
            check("t3_gnt_order", 512'(v), 512'(2'b01 << (i % 2)));
            wait_sig("t3_vld", 1, v, tv);
            check("t3_vld_owner", 512'(v), 512'(2'b01 << (i % 2)));
            check("t3_stream", stream, (i % 2 == 0) ? exp_stream(key0, cnt0) : exp_stream(key1, cnt1));
            if (i == 7) req = 2'b00;
        end
        @(negedge clk);
        @(negedge clk);
        check("t3_quiet", 512'({gnt, busy}), 512'd0);

        // Watchdog on the MAX_WAIT=16 instance after a good job from requester 1
        do_reset();
        eng_mode = 1;
        eng_lat  = 5;
        req      = 2'b10;
        wait_sig("t4_pre_gnt", 3, v, tg);
        check("t4_pre_gnt", 512'(v), 512'd2);
        req = 2'b00;
        wait_sig("t4_pre_vld", 4, v, tv);
        check("t4_pre_vld", 512'(v), 512'd2);
        check("t4_pre_stream", s_stream, exp_stream(key1, cnt1));
        eng_mode = 2;
        req      = 2'b11;
        wait_sig("t4_gnt", 3, v, ts);
        check("t4_gnt", 512'(v), 512'd1);
        check("t4_start", 512'(s_blk_start), 512'd1);
        req = 2'b10;
        wait_sig("t4_err", 5, v, te);
        check("t4_err", 512'(v), 512'd1);
        check("t4_err_lat", 512'(te - ts), 512'd16);
        check("t4_no_vld", 512'(s_vld), 512'd0);
        check("t4_stream_kept", s_stream, exp_stream(key1, cnt1));
        wait_sig("t4_next_gnt", 3, v, tg);
        check("t4_next_gnt", 512'(v), 512'd2);

        // Done arriving on the final watchdog cycle
        do_reset();
        eng_mode = 1;
        eng_lat  = 15;
        req      = 2'b01;
        wait_sig("t5_gnt", 3, v, ts);
        check("t5_gnt", 512'(v), 512'd1);
        req = 2'b00;
        wait_sig("t5_vld", 4, v, tv);
        check("t5_vld", 512'(v), 512'd1);
        check("t5_vld_lat", 512'(tv - ts), 512'd16);
        check("t5_no_err", 512'(s_err), 512'd0);
        check("t5_stream", s_stream, exp_stream(key0, cnt0));
        @(negedge clk);
        check("t5_no_err_after", 512'(s_err), 512'd0);

        // Reset in the middle of RUN; the engine's late done then lands in IDLE
        do_reset();
        eng_mode = 1;
        eng_lat  = 20;
        req      = 2'b01;
        wait_sig("t6_gnt", 0, v, tg);
        req = 2'b00;
        repeat (5) @(negedge clk);
        check("t6_busy_before", 512'(busy), 512'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_outs", 512'({gnt, vld, err, busy, blk_start}), 512'd0);
        check("t6_rst_blk", 512'({blk_key, blk_non, blk_cnt}), '0);
        check("t6_rst_stream", stream, '0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((gnt | vld | err) != 2'b00 || busy) hits++;
        end
        check("t6_no_response", 512'(hits), 512'd0);
        check("t6_stream_idle", stream, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cc_block_arb.md
Name: cc_block_arb

Overview:
- Round-robin arbiter and sequencer that shares one ChaCha20 keystream block engine (cc_block-style interface: start pulse, 256-bit key, 96-bit nonce, 32-bit counter, 512-bit stream, done pulse) between two requesters.
- Typical requesters: requester 0 is the encryptor (counter ≥1); requester 1 is the Poly1305 one-time-key generator (counter 0).
- Latches each request's operands, launches the engine, waits for completion with a watchdog, then returns the stream to the owner.

Parameters:
MAX_WAIT, 1024, maximum cycles spent in RUN without engine done before the job is aborted (≥2).

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous reset, active-high.
i_req  in  2  request per requester; bit n = requester n.
i_key0  in  256  requester 0 key.
i_non0  in  96  requester 0 nonce.
i_cnt0  in  32  requester 0 block counter.
i_key1  in  256  requester 1 key.
i_non1  in  96  requester 1 nonce.
i_cnt1  in  32  requester 1 block counter.
o_gnt  out  2  one-cycle grant pulse to the accepted requester.
o_vld  out  2  one-cycle result-valid pulse to the owner.
o_err  out  2  one-cycle timeout pulse to the owner.
o_stream  out  512  last returned keystream block.
o_busy  out  1  high whenever state is not IDLE.
o_blk_start  out  1  engine start pulse.
o_blk_key  out  256  engine key.
o_blk_non  out  96  engine nonce.
o_blk_cnt  out  32  engine counter.
i_blk_stream  in  512  engine keystream.
i_blk_done  in  1  engine completion pulse.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - State IDLE, round-robin pointer r_ptr=0.
  - All outputs 0: o_gnt, o_vld, o_err, o_stream, o_busy, o_blk_start, o_blk_key, o_blk_non, o_blk_cnt.
  - Wait counter = 0.
  - Reset mid-job abandons the job: no o_vld or o_err is ever issued for it.
- State machine: IDLE -> RUN -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If i_req is nonzero, select a requester:
    - Only one bit set: that requester.
    - Both bits set: requester r_ptr.
  - At that edge:
    - o_gnt[sel]<=1.
    - o_blk_start<=1.
    - o_blk_key/non/cnt <= sel's operands.
    - r_sel<=sel, wait counter<=0, state<=RUN.
  - Result: o_gnt and o_blk_start are both high for exactly one cycle, one cycle after i_req is first sampled.
  - i_blk_done in IDLE is ignored.
- Requester rule: hold i_req and operands stable until o_gnt is seen; deassert i_req in the o_gnt cycle. i_req is ignored in RUN and RESP.
- RUN:
  - o_blk_key/non/cnt are held constant; o_blk_start=0.
  - Wait counter increments each cycle.
  - On i_blk_done=1: o_stream<=i_blk_stream, o_vld[r_sel]<=1, state<=RESP.
  - Else, if wait counter==MAX_WAIT-1: o_err[r_sel]<=1, o_stream unchanged, state<=RESP.
  - i_blk_done and timeout in the same cycle: done wins; no o_err.
- RESP (exactly one cycle):
  - o_vld or o_err is high.
  - r_ptr<=~r_sel, so the other requester has priority next.
  - state<=IDLE.
- o_stream holds its value until the next successful completion.
- Throughput: a new grant can occur in the cycle after RESP. With a continuously pending request and an engine latency of L cycles from start to done, grants are spaced L+3 cycles apart.
- Starvation-free: with both requesters continuously pending, grants alternate 0,1,0,1,...
- o_busy = (state != IDLE), registered alongside the state.
- Counter and operand widths are passed through unchanged; the arbiter performs no arithmetic on operands.

Test Plan:
- Reset then single request:
  - Stimulus: i_req=01, cnt0=1, engine model with 20-cycle latency returning stream=0xA5..A5.
  - Required: o_gnt=01 and o_blk_start one cycle after request; o_blk_cnt=1; o_vld=01 one cycle after i_blk_done; o_stream=0xA5..A5; o_busy drops the cycle after RESP.
- Simultaneous requests from reset:
  - Stimulus: i_req=11.
  - Required: requester 0 granted first. With req1 still held, requester 1 is granted one cycle after RESP with o_blk_cnt=cnt1=0. Then re-raise both: requester 0 wins.
- Continuous contention:
  - Stimulus: both requesters pending for 8 jobs.
  - Required: grant order 0,1,0,1,0,1,0,1; each o_vld goes to the matching owner with that owner's stream.
- Timeout:
  - Stimulus: MAX_WAIT=16; engine never asserts done.
  - Required: o_err[sel] pulse exactly 16 cycles after o_blk_start; o_vld stays 0; o_stream unchanged; the other requester wins next.
- Done on the timeout cycle:
  - Stimulus: i_blk_done asserted in the cycle the counter reaches MAX_WAIT-1.
  - Required: o_vld pulses; o_err stays 0.
- Reset mid-RUN and stray done:
  - Stimulus: assert i_rst during RUN.
  - Required: all outputs 0 immediately; no o_vld afterwards.
  - Stimulus: a stray i_blk_done while IDLE.
  - Required: no response.
